chip8_fetch_unit: RTL
=====================

// Module: chip8_fetch_unit
// PURPOSE
//  Parametrised CHIP-8 instruction fetch front-end for the CPU core.
//  - Reads the 2-byte big-endian opcode at PC through a pipelined byte-wide memory port with configurable fixed read latency.
//  - Presents the opcode and its address to decode/execute over a valid/ready handshake.
//  - Accepts PC redirects (jumps, calls, skips) from execute, which abort any in-flight fetch.
// PARAMETERS
//  ADDR_W      12      address / PC width; all PC arithmetic is modulo 2^ADDR_W
//  RESET_PC    'h200   PC value after reset (CHIP-8 program load address)
//  MEM_LAT     1       memory read latency in cycles, legal range 1..4 (1 = synchronous RAM)
// PORTS
//  clk            in   1       clock, rising edge
//  reset_n        in   1       asynchronous active-low reset
//  run            in   1       1 = start new fetches; 0 = finish in-flight fetch, then idle
//  mem_addr_out   out  ADDR_W  byte address to program memory (registered)
//  mem_read       out  1       read strobe, one cycle per byte request (registered)
//  mem_data_in    in   8       read data, valid exactly MEM_LAT cycles after the strobe cycle
//  op_valid       out  1       op / op_pc hold a fetched opcode
//  op_ready       in   1       consumer accepts op this cycle
//  op             out  16      opcode {byte@PC, byte@PC+1}
//  op_pc          out  ADDR_W  address of op
//  redirect_valid in   1       load new PC this cycle
//  redirect_pc    in   ADDR_W  target PC
//  busy           out  1       a fetch is in flight or op_valid=1
//  perf_ops       out  16      [CHIP8_FETCH_PERF_EN only] opcodes delivered
//  perf_stalls    out  16      [CHIP8_FETCH_PERF_EN only] backpressure cycles
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, mem_addr_out=RESET_PC, mem_read=0, op_valid=0, op=0, op_pc=RESET_PC, busy=0, pending pipe empty, state IDLE.
//  - States:
//    - IDLE: if run=1 then REQ_HI.
//    - REQ_HI (1 cycle): mem_addr_out=pc, mem_read=1, go REQ_LO.
//    - REQ_LO (1 cycle): mem_addr_out=pc+1 (wraps), mem_read=1, go WAIT.
//    - WAIT: capture hi byte in cycle t+MEM_LAT and lo byte in t+MEM_LAT+1 (t = REQ_HI cycle); then go PRESENT.
//    - PRESENT: op_valid=1; op/op_pc stable until handshake.
//  - A 2-deep-per-latency pending pipe (hi/lo tags) tracks outstanding reads; mem_read is 0 in every state except REQ_HI/REQ_LO.
//  - Latency: op_valid rises in cycle t+MEM_LAT+2. With MEM_LAT=1 this is 3 cycles after REQ_HI.
//  - Handshake (op_valid & op_ready): pc<=pc+2 mod 2^ADDR_W.
//    - run=1: next cycle is REQ_HI, op_valid=0 (no prefetch overlap).
//    - run=0: next cycle is IDLE.
//  - op_ready while op_valid=0 is ignored.
//  - Redirect, any state: pc<=redirect_pc; pending pipe flushed, so returning data is discarded; op_valid=0 next cycle; next state REQ_HI if run=1 else IDLE.
//  - Redirect in the same cycle as a handshake: the opcode counts as consumed and the redirect wins over pc+2.
//  - Redirect during REQ_HI/REQ_LO: the strobe that cycle still goes out but is flushed.
//  - run deasserted mid-fetch: current opcode completes and is presented, then IDLE.
//  - Wrap-around:
//    - pc=max-1 (e.g. 'hFFE): bytes at FFE,FFF; next pc=000.
//    - Odd pc=max ('hFFF, via redirect): bytes at FFF,000.
//  - busy = (state != IDLE).
// CONFIGURATION
//  - CHIP8_FETCH_PERF_EN defined:
//    - perf_ops increments on each handshake.
//    - perf_stalls increments each cycle with op_valid=1 & op_ready=0.
//    - Both are 16-bit, saturate at 'hFFFF, and reset to 0.
//  - CHIP8_FETCH_PERF_EN undefined: perf ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. MEM_LAT=1, mem[200]=00, mem[201]=E0, run=1, op_ready=1 after reset: strobes at 200 then 201; op_valid in cycle 3 with op=00E0, op_pc=200; next REQ_HI addresses 202.
//  2. Backpressure: op_ready=0 for 5 cycles while op_valid=1: op/op_pc stable, no mem_read; ready then gives one handshake and pc=202; perf_stalls=5 (macro on).
//  3. Redirect_pc=300 in the cycle after REQ_LO at 200: stale bytes discarded; next strobes 300,301; op_pc=300 with mem[300..301] data.
//  4. Redirect to FFE then FFF (ADDR_W=12): strobes FFE,FFF then pc=000; for FFF strobes FFF,000, op_pc=FFF.
//  5. MEM_LAT=3: op_valid exactly 5 cycles after REQ_HI. Redirect in the same cycle as a handshake: pc=redirect_pc, not pc+2.
//  6. run=0 mid-WAIT: opcode delivered, then IDLE with busy=0 and no strobes; reset_n pulse mid-fetch returns all outputs to reset values immediately.

Source files
------------

// File: rtl/chip8_fetch_unit.sv
// CHIP-8 instruction fetch front-end: two byte reads per opcode over a fixed-latency memory port,
// valid/ready opcode output, PC redirect with flush. Optional counters under CHIP8_FETCH_PERF_EN.
module chip8_fetch_unit #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('h200),
    parameter int                 MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_read,
    input  logic [7:0]        mem_data_in,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       op,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic [2:0]        state_dbg
`ifdef CHIP8_FETCH_PERF_EN
    ,
    output logic [15:0]       perf_ops,
    output logic [15:0]       perf_stalls
`endif
);

    // Handshake: an opcode transfers in every cycle where op_valid and op_ready are both 1;
    // op/op_pc hold steady while op_valid=1 and op_ready=0. op_ready is ignored while op_valid=0.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_HI  = 3'd1,
        REQ_LO  = 3'd2,
        WAIT    = 3'd3,
        PRESENT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   op_pc_q;
    logic                rd_q;
    logic                valid_q;
    logic [15:0]         op_q;
    logic [7:0]          hi_byte_q;
    logic [MEM_LAT-1:0]  hi_pipe_q, hi_pipe_d;
    logic [MEM_LAT-1:0]  lo_pipe_q, lo_pipe_d;
    logic                hi_arrive;
    logic                lo_arrive;

    // Tag pipes: stage i is set when the strobe issued i+1 cycles ago was the hi / lo byte.
    always_comb begin
        hi_pipe_d    = '0;
        lo_pipe_d    = '0;
        hi_pipe_d[0] = (state_q == REQ_HI);
        lo_pipe_d[0] = (state_q == REQ_LO);
        for (int i = 1; i < MEM_LAT; i++) begin
            hi_pipe_d[i] = hi_pipe_q[i-1];
            lo_pipe_d[i] = lo_pipe_q[i-1];
        end
        if (redirect_valid) begin
            hi_pipe_d = '0;
            lo_pipe_d = '0;
        end
    end

    assign hi_arrive = hi_pipe_q[MEM_LAT-1];
    assign lo_arrive = lo_pipe_q[MEM_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            op_pc_q   <= RESET_PC;
            rd_q      <= 1'b0;
            valid_q   <= 1'b0;
            op_q      <= 16'h0000;
            hi_byte_q <= 8'h00;
            hi_pipe_q <= '0;
            lo_pipe_q <= '0;
        end else begin
            hi_pipe_q <= hi_pipe_d;
            lo_pipe_q <= lo_pipe_d;
            if (hi_arrive) begin
                hi_byte_q <= mem_data_in;
            end
            if (redirect_valid) begin
                // Wins over everything, including a same-cycle handshake's pc+2.
                pc_q    <= redirect_pc;
                valid_q <= 1'b0;
                if (run) begin
                    state_q <= REQ_HI;
                    addr_q  <= redirect_pc;
                    rd_q    <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (run) begin
                            state_q <= REQ_HI;
                            addr_q  <= pc_q;
                            rd_q    <= 1'b1;
                        end
                    end
                    REQ_HI: begin
                        state_q <= REQ_LO;
                        addr_q  <= pc_q + PC_ONE;
                        rd_q    <= 1'b1;
                    end
                    REQ_LO: begin
                        state_q <= WAIT;
                        rd_q    <= 1'b0;
                    end
                    WAIT: begin
                        if (lo_arrive) begin
                            op_q    <= {hi_byte_q, mem_data_in};
                            op_pc_q <= pc_q;
                            valid_q <= 1'b1;
                            state_q <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (op_ready) begin
                            pc_q    <= pc_q + PC_TWO;
                            valid_q <= 1'b0;
                            if (run) begin
                                state_q <= REQ_HI;
                                addr_q  <= pc_q + PC_TWO;
                                rd_q    <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_addr_out = addr_q;
    assign mem_read     = rd_q;
    assign op_valid     = valid_q;
    assign op           = op_q;
    assign op_pc        = op_pc_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;

`ifdef CHIP8_FETCH_PERF_EN
    logic [15:0] perf_ops_q;
    logic [15:0] perf_stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops_q    <= 16'h0000;
            perf_stalls_q <= 16'h0000;
        end else begin
            if (valid_q && op_ready && (perf_ops_q != 16'hFFFF)) begin
                perf_ops_q <= perf_ops_q + 16'h0001;
            end
            if (valid_q && !op_ready && (perf_stalls_q != 16'hFFFF)) begin
                perf_stalls_q <= perf_stalls_q + 16'h0001;
            end
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
